// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a debug/loader port share one
// single-ported memory with a fixed read latency. Requests are arbitrated
// round-robin, one transaction at a time, through IDLE/ACCESS/WAIT/RESP.
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The WAIT counter starts at RD_LAT-1 and leaves WAIT when it reaches 0,
  // so WAIT always spans exactly RD_LAT cycles.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t      state;
  state_t      state_next;
  logic        ptr;
  logic        owner_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  lat_cnt;
  logic [31:0] rdata_q;
  logic [31:0] cpu_hold_q;
  logic [31:0] dbg_hold_q;
  logic        any_req;
  logic        sel_dbg;

  // Winner selection: a lone requester always wins; on contention the side
  // favoured by the pointer (1 = debug) wins.
  always_comb begin
    any_req = cpu_req | dbg_req;
    sel_dbg = dbg_req & (~cpu_req | ptr);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ACCESS is always one cycle, writes finish there.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = we_q ? IDLE : WAIT;
      WAIT:    if (lat_cnt == 2'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction registers: latch the winner at selection, flip the pointer
  // when the access is issued, count down the read latency, capture the
  // read data on the last WAIT edge and keep per-port copies after delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      rdata_q    <= '0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= sel_dbg;
            we_q    <= sel_dbg ? dbg_we    : cpu_we;
            addr_q  <= sel_dbg ? dbg_addr  : cpu_addr;
            wdata_q <= sel_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          ptr     <= ~owner_q;
          lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            rdata_q <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (owner_q) begin
            dbg_hold_q <= rdata_q;
          end else begin
            cpu_hold_q <= rdata_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: memory strobes only in ACCESS, handshakes only to the
  // owner, and the read data shows the fresh value during its rvalid cycle.
  always_comb begin
    busy       = (state != IDLE);
    owner      = owner_q;
    mem_en     = (state == ACCESS);
    mem_we     = (state == ACCESS) ? we_q    : 1'b0;
    mem_addr   = (state == ACCESS) ? addr_q  : '0;
    mem_wdata  = (state == ACCESS) ? wdata_q : '0;
    cpu_gnt    = (state == ACCESS) && !owner_q;
    dbg_gnt    = (state == ACCESS) &&  owner_q;
    cpu_rvalid = (state == RESP)   && !owner_q;
    dbg_rvalid = (state == RESP)   &&  owner_q;
    cpu_rdata  = cpu_rvalid ? rdata_q : cpu_hold_q;
    dbg_rdata  = dbg_rvalid ? rdata_q : dbg_hold_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with RD_LAT = 2 and a small memory model
// that returns the expected read word only in the correct latency cycle.
module tb_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] read_value = 32'h0;
  logic [31:0] pipe0 = 32'h0;
  logic [31:0] pipe1 = 32'h0;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle N presents read_value in cycle
  // N+2 only; every other cycle shows a junk word.
  always @(posedge clk) begin
    pipe0 <= (mem_en && !mem_we) ? read_value : 32'hDEADDEAD;
    pipe1 <= pipe0;
  end
  assign mem_rdata = pipe1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    check1({tag, ".busy"}, busy, 1'b0);
    check1({tag, ".mem_en"}, mem_en, 1'b0);
    check1({tag, ".cpu_gnt"}, cpu_gnt, 1'b0);
    check1({tag, ".dbg_gnt"}, dbg_gnt, 1'b0);
    check1({tag, ".cpu_rvalid"}, cpu_rvalid, 1'b0);
    check1({tag, ".dbg_rvalid"}, dbg_rvalid, 1'b0);
  endtask

  task automatic checkReset(input string tag);
    checkQuiet(tag);
    check1({tag, ".mem_we"}, mem_we, 1'b0);
    check32({tag, ".mem_addr"}, mem_addr, 32'h0);
    check32({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    check32({tag, ".cpu_rdata"}, cpu_rdata, 32'h0);
    check32({tag, ".dbg_rdata"}, dbg_rdata, 32'h0);
    check1({tag, ".owner"}, owner, 1'b0);
  endtask

  task automatic checkGrant(input string tag, input logic dbg_side, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    check1({tag, ".cpu_gnt"}, cpu_gnt, !dbg_side);
    check1({tag, ".dbg_gnt"}, dbg_gnt, dbg_side);
    check1({tag, ".owner"}, owner, dbg_side);
    check1({tag, ".mem_en"}, mem_en, 1'b1);
    check1({tag, ".mem_we"}, mem_we, we);
    check32({tag, ".mem_addr"}, mem_addr, addr);
    if (we) check32({tag, ".mem_wdata"}, mem_wdata, wdata);
  endtask

  initial begin
    // Reset with both ports requesting writes.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h11111111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h22222222;
    tick();
    checkReset("rst1");
    tick();
    checkReset("rst2");
    reset = 1'b0;

    // Continuous contention: grants alternate starting with the CPU.
    tick();
    checkGrant("cont1", 1'b0, 1'b1, 32'h100, 32'h11111111);
    tick();
    checkQuiet("cont1_idle");
    tick();
    checkGrant("cont2", 1'b1, 1'b1, 32'h200, 32'h22222222);
    tick();
    checkQuiet("cont2_idle");
    tick();
    checkGrant("cont3", 1'b0, 1'b1, 32'h100, 32'h11111111);
    tick();
    tick();
    checkGrant("cont4", 1'b1, 1'b1, 32'h200, 32'h22222222);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    checkQuiet("cont_end");

    // CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h00000010; cpu_wdata = 32'hDEADBEEF;
    tick();
    checkGrant("cpuwr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();
    checkQuiet("cpuwr_done");
    check32("cpuwr_done.mem_addr", mem_addr, 32'h0);

    // Debug read, memory answers two cycles after mem_en.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; read_value = 32'h12345678;
    tick();
    checkGrant("dbgrd", 1'b1, 1'b0, 32'h40, 32'h0);
    dbg_req = 1'b0;
    tick();
    check1("dbgrd_w1.busy", busy, 1'b1);
    check1("dbgrd_w1.mem_en", mem_en, 1'b0);
    check1("dbgrd_w1.dbg_rvalid", dbg_rvalid, 1'b0);
    tick();
    check1("dbgrd_w2.dbg_rvalid", dbg_rvalid, 1'b0);
    check32("dbgrd_w2.mem_addr", mem_addr, 32'h0);
    tick();
    check1("dbgrd_resp.dbg_rvalid", dbg_rvalid, 1'b1);
    check1("dbgrd_resp.cpu_rvalid", cpu_rvalid, 1'b0);
    check32("dbgrd_resp.dbg_rdata", dbg_rdata, 32'h12345678);
    check1("dbgrd_resp.busy", busy, 1'b1);
    tick();
    checkQuiet("dbgrd_after");
    check32("dbgrd_after.dbg_rdata", dbg_rdata, 32'h12345678);

    // CPU read with req dropped during the ACCESS cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; read_value = 32'hCAFEF00D;
    tick();
    checkGrant("late", 1'b0, 1'b0, 32'h80, 32'h0);
    cpu_req = 1'b0;
    tick();
    check1("late_w1.cpu_rvalid", cpu_rvalid, 1'b0);
    tick();
    check1("late_w2.cpu_rvalid", cpu_rvalid, 1'b0);
    tick();
    check1("late_resp.cpu_rvalid", cpu_rvalid, 1'b1);
    check1("late_resp.dbg_rvalid", dbg_rvalid, 1'b0);
    check32("late_resp.cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    check32("late_resp.dbg_rdata", dbg_rdata, 32'h12345678);
    tick();
    checkQuiet("late_after");
    check32("late_after.cpu_rdata", cpu_rdata, 32'hCAFEF00D);

    // CPU read abandoned by reset in WAIT; pointer would favour debug
    // without the reset, so the next contention must still go to the CPU.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; read_value = 32'h55555555;
    tick();
    checkGrant("midrd", 1'b0, 1'b0, 32'h44, 32'h0);
    cpu_req = 1'b0;
    tick();
    check1("midrd_wait.busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    checkReset("midrd_rst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkQuiet("midrd_quiet");
      check32("midrd_quiet.cpu_rdata", cpu_rdata, 32'h0);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h33333333;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h400; dbg_wdata = 32'h44444444;
    tick();
    checkGrant("post_rst", 1'b0, 1'b1, 32'h300, 32'h33333333);
    cpu_req = 1'b0;
    tick();
    tick();
    checkGrant("post_rst_dbg", 1'b1, 1'b1, 32'h400, 32'h44444444);
    dbg_req = 1'b0;
    tick();
    checkQuiet("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
